// File: rtl/izhikevich_pkg.sv
// Shared definitions for the Izhikevich neuron array.
//   - cfg_sel encodings for the configuration write port
//   - sweep FSM state enum
//   - sat_n: clamp a wide signed value into an n-bit signed range
//   - Q2.16 default constants for the 1.4 term and the spike threshold
package izhikevich_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_MULT,
    ST_UPDATE
  } state_e;

  localparam logic [2:0] SEL_V    = 3'd0;
  localparam logic [2:0] SEL_U    = 3'd1;
  localparam logic [2:0] SEL_A    = 3'd2;
  localparam logic [2:0] SEL_B    = 3'd3;
  localparam logic [2:0] SEL_C    = 3'd4;
  localparam logic [2:0] SEL_D    = 3'd5;
  localparam logic [2:0] SEL_I    = 3'd6;
  localparam logic [2:0] SEL_RSVD = 3'd7;

  localparam logic signed [17:0] C14_DEFAULT = 18'sh1_6666;  // 1.4
  localparam logic signed [17:0] VTH_DEFAULT = 18'sh0_4CCC;  // 0.3

  // Callers sign-extend into 64 bits and cast the result back to n bits,
  // so one function serves every width up to 63.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] x,
                                               input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/izh_fixed_mult.sv
// Signed fixed-point multiplier: full 2N-bit product, arithmetic shift right
// by F fractional bits, then saturation back to N bits.
// Ports:
//   a_i, b_i  signed N-bit operands
//   p_o       signed N-bit saturated product
module izh_fixed_mult
  import izhikevich_pkg::*;
#(
  parameter int N = 18,
  parameter int F = 16
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic signed [N-1:0] p_o
);

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] prod_shifted;

  assign prod         = (2*N)'(a_i) * (2*N)'(b_i);
  assign prod_shifted = prod >>> F;
  assign p_o          = N'(sat_n(64'(prod_shifted), N));

endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed array of NUM_NEURONS Izhikevich neurons sharing one
// fixed-point Euler-update datapath. A start pulse sweeps every neuron once
// (READ -> MULT -> UPDATE, three cycles each) and leaves a spike vector.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   v_init, u_init      state loaded into every neuron on reset
//   v_th, c14           threshold and constant term, captured on start
//   start/busy/done     sweep handshake (done is a one-cycle pulse)
//   spikes              spike bit per neuron from the last sweep
//   cfg_we/addr/sel/data  per-neuron state/parameter write port (idle only)
//   cfg_err             one-cycle pulse one cycle after a rejected write
//   rd_v, rd_u          combinational readback of neuron cfg_addr
module izhikevich_array
  import izhikevich_pkg::*;
#(
  parameter int N           = 18,
  parameter int F           = 16,
  parameter int NUM_NEURONS = 8,
  parameter int DT_SHIFT    = 4,
  parameter int AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [N-1:0]    v_init,
  input  logic signed [N-1:0]    u_init,
  input  logic signed [N-1:0]    v_th,
  input  logic signed [N-1:0]    c14,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spikes,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [2:0]             cfg_sel,
  input  logic signed [N-1:0]    cfg_data,
  output logic                   cfg_err,
  output logic signed [N-1:0]    rd_v,
  output logic signed [N-1:0]    rd_u
);

  // Sum width: the dv terms add up to under 4x full scale, so three guard
  // bits keep the intermediate sums exact before saturation.
  localparam int W = N + 3;

  // Control
  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   cfg_err_q;
  logic [NUM_NEURONS-1:0] spikes_q;
  logic                   idx_last;
  logic                   start_accept;
  logic                   cfg_addr_ok;
  logic                   cfg_accept;

  // Register files
  logic signed [N-1:0] v_rf_q [NUM_NEURONS];
  logic signed [N-1:0] u_rf_q [NUM_NEURONS];
  logic signed [N-1:0] a_rf_q [NUM_NEURONS];
  logic signed [N-1:0] b_rf_q [NUM_NEURONS];
  logic signed [N-1:0] c_rf_q [NUM_NEURONS];
  logic signed [N-1:0] d_rf_q [NUM_NEURONS];
  logic signed [N-1:0] i_rf_q [NUM_NEURONS];

  // Sweep-constant inputs and per-neuron pipeline registers
  logic signed [N-1:0] vth_q, c14_q;
  logic signed [N-1:0] cur_v_q, cur_u_q, cur_a_q, cur_b_q;
  logic signed [N-1:0] cur_c_q, cur_d_q, cur_i_q;
  logic signed [N-1:0] vsq_q, bv_q;

  // Update datapath
  logic signed [N-1:0] vsq_p, bv_p, du_p;
  logic signed [N-1:0] bv_minus_u;
  logic signed [W-1:0] dv;
  logic signed [N-1:0] v_calc, u_calc, u_spike;
  logic signed [N-1:0] v_wb, u_wb;
  logic                spike;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  assign idx_last     = (32'(idx_q) == NUM_NEURONS - 1);
  assign start_accept = (state_q == ST_IDLE) && start;
  assign cfg_addr_ok  = (32'(cfg_addr) < NUM_NEURONS);
  // Writes only land between sweeps, so the write port never races the
  // UPDATE write-back into the same register file.
  assign cfg_accept   = cfg_we && (state_q == ST_IDLE) && !start &&
                        (cfg_sel != SEL_RSVD) && cfg_addr_ok;

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ:   state_d = ST_MULT;
      ST_MULT:   state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (idx_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          idx_d   = idx_q + AW'(1);
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      spikes_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_we && !cfg_accept;
      if (state_q == ST_UPDATE) begin
        spikes_q[idx_q] <= spike;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register files: config writes when idle, sweep write-back in UPDATE
  // ---------------------------------------------------------------------
  // NOTE: these flop-based register files are reset explicitly because the
  // reset contents (v_init/u_init, zero parameters) are architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_rf_q[n] <= v_init;
        u_rf_q[n] <= u_init;
        a_rf_q[n] <= '0;
        b_rf_q[n] <= '0;
        c_rf_q[n] <= '0;
        d_rf_q[n] <= '0;
        i_rf_q[n] <= '0;
      end
    end else begin
      if (cfg_accept) begin
        unique case (cfg_sel)
          SEL_V:   v_rf_q[cfg_addr] <= cfg_data;
          SEL_U:   u_rf_q[cfg_addr] <= cfg_data;
          SEL_A:   a_rf_q[cfg_addr] <= cfg_data;
          SEL_B:   b_rf_q[cfg_addr] <= cfg_data;
          SEL_C:   c_rf_q[cfg_addr] <= cfg_data;
          SEL_D:   d_rf_q[cfg_addr] <= cfg_data;
          SEL_I:   i_rf_q[cfg_addr] <= cfg_data;
          default: ;
        endcase
      end
      if (state_q == ST_UPDATE) begin
        v_rf_q[idx_q] <= v_wb;
        u_rf_q[idx_q] <= u_wb;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline registers: no reset needed, every value is written before use
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (start_accept) begin
      vth_q <= v_th;
      c14_q <= c14;
    end
    if (state_q == ST_READ) begin
      cur_v_q <= v_rf_q[idx_q];
      cur_u_q <= u_rf_q[idx_q];
      cur_a_q <= a_rf_q[idx_q];
      cur_b_q <= b_rf_q[idx_q];
      cur_c_q <= c_rf_q[idx_q];
      cur_d_q <= d_rf_q[idx_q];
      cur_i_q <= i_rf_q[idx_q];
    end
    if (state_q == ST_MULT) begin
      vsq_q <= vsq_p;
      bv_q  <= bv_p;
    end
  end

  // ---------------------------------------------------------------------
  // Update datapath
  // ---------------------------------------------------------------------
  izh_fixed_mult #(.N(N), .F(F)) u_mult_vsq (
    .a_i (cur_v_q),
    .b_i (cur_v_q),
    .p_o (vsq_p)
  );

  izh_fixed_mult #(.N(N), .F(F)) u_mult_bv (
    .a_i (cur_b_q),
    .b_i (cur_v_q),
    .p_o (bv_p)
  );

  izh_fixed_mult #(.N(N), .F(F)) u_mult_du (
    .a_i (cur_a_q),
    .b_i (bv_minus_u),
    .p_o (du_p)
  );

  // dv = v^2 + v + v/4 + 1.4/4 - u/4 + i/4
  assign dv = W'(vsq_q) + W'(cur_v_q) + W'(cur_v_q >>> 2) +
              W'(c14_q >>> 2) - W'(cur_u_q >>> 2) + W'(cur_i_q >>> 2);

  assign v_calc     = N'(sat_n(64'(W'(cur_v_q) + (dv >>> 2)), N));
  assign bv_minus_u = N'(sat_n(64'(W'(bv_q) - W'(cur_u_q)), N));
  assign u_calc     = N'(sat_n(64'(W'(cur_u_q) + W'(du_p >>> DT_SHIFT)), N));
  assign u_spike    = N'(sat_n(64'(W'(cur_u_q) + W'(cur_d_q)), N));

  // Spike decision uses the value read this sweep, not the updated one.
  assign spike = (cur_v_q > vth_q);
  assign v_wb  = spike ? cur_c_q : v_calc;
  assign u_wb  = spike ? u_spike : u_calc;

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign spikes  = spikes_q;
  assign cfg_err = cfg_err_q;
  assign rd_v    = cfg_addr_ok ? v_rf_q[cfg_addr] : '0;
  assign rd_u    = cfg_addr_ok ? u_rf_q[cfg_addr] : '0;

endmodule

// File: doc/izhikevich_array.md
Name: izhikevich_array

Overview:
- Time-multiplexed array of NUM_NEURONS Izhikevich neurons sharing one fixed-point update datapath.
- Per-neuron state (v, u) and per-neuron parameters (a, b, c, d, i) are held in register files.
- One start pulse runs one Euler timestep over all neurons and produces a spike vector.
- Successor to the single-neuron core: parametrised width and neuron count, true multipliers for a/b, saturating arithmetic, and a config write port.

Parameters:
- N, 18, total signed fixed-point width.
- F, 16, fractional bits (default Q2.16: 18'sh1_6666 = 1.4).
- NUM_NEURONS, 8, neurons in the array (>= 1).
- DT_SHIFT, 4, u-update scaling: du applied as >>> DT_SHIFT.
- AW, $clog2(NUM_NEURONS) (min 1), neuron address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- v_init  in  N  v value loaded into every neuron on reset
- u_init  in  N  u value loaded into every neuron on reset
- v_th  in  N  spike threshold; sampled on accepted start
- c14  in  N  constant term (1.4); sampled on accepted start
- start  in  1  one-cycle pulse; begins one timestep sweep
- busy  out  1  high while a sweep runs
- done  out  1  one-cycle pulse when a sweep completes
- spikes  out  NUM_NEURONS  spike bit per neuron from the last sweep
- cfg_we  in  1  config write strobe
- cfg_addr  in  AW  neuron index
- cfg_sel  in  3  0=v 1=u 2=a 3=b 4=c 5=d 6=i; 7 reserved, write ignored
- cfg_data  in  N  write data
- cfg_err  out  1  one-cycle pulse when a write is rejected
- rd_v  out  N  v of neuron cfg_addr (combinational readback)
- rd_u  out  N  u of neuron cfg_addr (combinational readback)

Behaviour:
- Reset (sync, active-high): every v <= v_init, every u <= u_init; a, b, c, d, i <= 0; busy=0, done=0, spikes=0, cfg_err=0; FSM to IDLE. Reset mid-sweep aborts it; no done pulse.
- FSM states: IDLE, READ, MULT, UPDATE. Each neuron takes 3 cycles; a sweep takes 3*NUM_NEURONS cycles.
  - IDLE: start=1 latches v_th and c14, clears the index, goes to READ; busy goes high the next cycle.
  - READ: registers v, u and params of the current neuron.
  - MULT: registers v*v and b*v through izh_fixed_mult.
  - UPDATE: writes back the new v and u and the spike bit. If the index is the last neuron, goes to IDLE with done=1 for exactly one cycle and busy=0 in the same cycle. Otherwise increments the index and goes to READ.
  - start while busy is ignored.
- Multiply: full 2N-bit signed product, arithmetic shift right by F, then saturate to N bits.
- Intermediate sums use N+3 bits. Every value written to v or u is saturated to [-2^(N-1), 2^(N-1)-1].
- Non-spiking update (v <= v_th):
  - dv = vsq + v + (v>>>2) + (c14>>>2) - (u>>>2) + (i>>>2)
  - v_new = sat(v + (dv>>>2))
  - du = mult(a, sat(bv - u))
  - u_new = sat(u + (du>>>DT_SHIFT))
- Spike (v > v_th, strict comparison on the value read in READ): v <= c, u <= sat(u + d), spike bit = 1. Otherwise the spike bit = 0.
- spikes bits are updated per neuron during the sweep. All bits are stable and valid from the done cycle until the next accepted start.
- Config writes:
  - Accepted only while busy=0 and no start is asserted in the same cycle; take effect next cycle.
  - A write while busy, in the same cycle as start, or with cfg_sel=7 is dropped, and cfg_err pulses 1 cycle later.
  - cfg_addr >= NUM_NEURONS: write dropped, cfg_err pulses.
- rd_v and rd_u are valid at any time; they reflect the stored state, not in-flight values.

Decomposition:
- Package izhikevich_pkg:
  - cfg_sel encodings (SEL_V..SEL_I) and FSM state enum.
  - Saturation function sat_n.
  - Q2.16 constants: C14_DEFAULT=18'sh1_6666, VTH_DEFAULT=18'sh0_4CCC.
- Sub-module izh_fixed_mult (parameter N, F): signed multiply, >>>F, saturate. Instantiated twice (v*v and b*v) plus once for a*(bv-u).

Test Plan:
- Reset with v_init=18'sh3_4CCD (-0.7), u_init=18'sh3_CCCD (-0.2) -> rd_v/rd_u equal these for all addresses; spikes=0, busy=0.
- Neuron 0: a=0.02, b=0.2, i=18'sh0_2666 (0.15), c14=1.4, v_th=0.3; one start -> done exactly 3*NUM_NEURONS+1 cycles after start; v ~ -0.686875 and u ~ -0.199925, each within 2 LSB of the bit-accurate model; spikes[0]=0.
- Write v=18'sh0_6666 (0.4) and c=18'sh3_8000, d=18'sh0_051E to neuron 3; sweep -> spikes[3]=1, v=18'sh3_8000, u=u_old+0x051E. Write v=v_th exactly -> no spike.
- Saturation: v=18'sh1_E666 (1.9), i=18'sh1_FFFF -> v_new=18'sh1_FFFF, no wrap to negative.
- Write during busy, same-cycle write+start, cfg_sel=7, and cfg_addr=NUM_NEURONS -> each produces a cfg_err pulse and leaves state unchanged; start during busy -> no extra done.
- Reset asserted mid-sweep (cycle 5) -> busy=0 next cycle, no done, all state returns to v_init/u_init; a fresh sweep then completes normally.
